// File: rtl/qos_channel_selector.sv
// QoS core of the 4-input TS redundancy switch: tracks per-channel presence and windowed
// error counts, and picks active_channel manually, by fixed priority, or by holdoff-guarded fallback.
module qos_channel_selector #(
   parameter int         SIGNAL_TIMEOUT = 27000,
   parameter logic [7:0] ERR_THRESH     = 8'd16,
   parameter int         HOLDOFF        = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  pkt_valid,
   input  logic [3:0]  pkt_err,
   input  logic        fallback_enable,
   input  logic        manual_enable,
   input  logic [1:0]  manual_channel,
   input  logic [7:0]  channel_priority,
   input  logic [19:0] reset_timer,
   input  logic        valid_config,
   output logic [1:0]  active_channel,
   output logic [3:0]  signal_present,
   output logic [7:0]  error_count_ch0,
   output logic [7:0]  error_count_ch1,
   output logic [7:0]  error_count_ch2,
   output logic [7:0]  error_count_ch3,
   output logic        switch_event
);

   localparam logic [19:0] TIMEOUT    = 20'(SIGNAL_TIMEOUT);
   localparam logic [19:0] HOLD_CYC   = 20'(HOLDOFF);
   localparam logic [0:0]  ST_LOCKED  = 1'b0;
   localparam logic [0:0]  ST_PENDING = 1'b1;

   logic        fallback_q, manual_q;
   logic [1:0]  manual_ch_q;
   logic [7:0]  prio_q;
   logic [19:0] rtimer_q;

   logic [19:0] pres_cnt_q [4];
   logic [19:0] pres_cnt_d [4];
   logic [3:0]  present_q, present_d;
   logic [7:0]  err_q [4];
   logic [7:0]  err_d [4];
   logic [19:0] win_q, win_d;
   logic        win_wrap, win_clear;

   logic [3:0]  healthy;
   logic [1:0]  cand;
   logic        cand_valid, cur_healthy;

   logic [1:0]  active_q, active_d;
   logic        switch_q, switch_d;
   logic [0:0]  state_q, state_d;
   logic [19:0] hold_q, hold_d;
   logic [1:0]  pend_q, pend_d;

   assign win_wrap  = (rtimer_q != 20'd0) && (win_q == rtimer_q - 20'd1);
   assign win_clear = valid_config || win_wrap;

   always_comb begin
      if (win_clear)
         win_d = 20'd0;
      else if (rtimer_q != 20'd0)
         win_d = win_q + 20'd1;
      else
         win_d = win_q;
   end

   // Status side: presence age, error counters (clear first, then count), health.
   always_comb begin
      present_d = '0;
      healthy   = '0;
      for (int n = 0; n < 4; n++) begin
         if (pkt_valid[n])
            pres_cnt_d[n] = 20'd0;
         else if (pres_cnt_q[n] < TIMEOUT)
            pres_cnt_d[n] = pres_cnt_q[n] + 20'd1;
         else
            pres_cnt_d[n] = pres_cnt_q[n];
         present_d[n] = (pres_cnt_d[n] < TIMEOUT);

         err_d[n] = win_clear ? 8'd0 : err_q[n];
         if (pkt_valid[n] && pkt_err[n] && (err_d[n] != 8'hFF))
            err_d[n] = err_d[n] + 8'd1;

         healthy[n] = present_q[n] && (err_q[n] < ERR_THRESH);
      end
   end

   // Walk priority from last to first so the earliest healthy entry wins.
   always_comb begin
      cand       = 2'd0;
      cand_valid = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (healthy[prio_q[2*i +: 2]]) begin
            cand       = prio_q[2*i +: 2];
            cand_valid = 1'b1;
         end
      end
   end

   assign cur_healthy = healthy[active_q];

   always_comb begin
      active_d = active_q;
      state_d  = ST_LOCKED;
      hold_d   = hold_q;
      pend_d   = pend_q;
      if (manual_q) begin
         active_d = manual_ch_q;
      end else if (!fallback_q) begin
         active_d = prio_q[1:0];
      end else if (state_q == ST_LOCKED) begin
         if (cand_valid && (cand != active_q)) begin
            if (!cur_healthy) begin
               active_d = cand;
            end else begin
               state_d = ST_PENDING;
               hold_d  = 20'd1;
               pend_d  = cand;
            end
         end
      end else if (cand_valid && (cand == pend_q) && (cand != active_q)) begin
         if (!cur_healthy || (hold_q >= HOLD_CYC)) begin
            active_d = cand;
         end else begin
            state_d = ST_PENDING;
            hold_d  = hold_q + 20'd1;
         end
      end
      // A new configuration discards any holdoff in progress.
      if (valid_config)
         state_d = ST_LOCKED;
      switch_d = (active_d != active_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fallback_q  <= 1'b0;
         manual_q    <= 1'b0;
         manual_ch_q <= 2'd0;
         prio_q      <= 8'd0;
         rtimer_q    <= 20'd0;
         for (int n = 0; n < 4; n++) begin
            pres_cnt_q[n] <= TIMEOUT;
            err_q[n]      <= 8'd0;
         end
         present_q <= 4'd0;
         win_q     <= 20'd0;
         active_q  <= 2'd0;
         switch_q  <= 1'b0;
         state_q   <= ST_LOCKED;
         hold_q    <= 20'd0;
         pend_q    <= 2'd0;
      end else begin
         if (valid_config) begin
            fallback_q  <= fallback_enable;
            manual_q    <= manual_enable;
            manual_ch_q <= manual_channel;
            prio_q      <= channel_priority;
            rtimer_q    <= reset_timer;
         end
         for (int n = 0; n < 4; n++) begin
            pres_cnt_q[n] <= pres_cnt_d[n];
            err_q[n]      <= err_d[n];
         end
         present_q <= present_d;
         win_q     <= win_d;
         active_q  <= active_d;
         switch_q  <= switch_d;
         state_q   <= state_d;
         hold_q    <= hold_d;
         pend_q    <= pend_d;
      end
   end

   assign active_channel  = active_q;
   assign signal_present  = present_q;
   assign error_count_ch0 = err_q[0];
   assign error_count_ch1 = err_q[1];
   assign error_count_ch2 = err_q[2];
   assign error_count_ch3 = err_q[3];
   assign switch_event    = switch_q;

endmodule

// File: tb/tb_qos_channel_selector.sv
// Scoreboard bench for qos_channel_selector: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-indexed behavioural model.
module tb_qos_channel_selector;
   localparam int ST = 40;
   localparam int ET = 16;
   localparam int HO = 30;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  pkt_valid = '0;
   logic [3:0]  pkt_err = '0;
   logic        fallback_enable = 1'b0;
   logic        manual_enable = 1'b0;
   logic [1:0]  manual_channel = '0;
   logic [7:0]  channel_priority = '0;
   logic [19:0] reset_timer = '0;
   logic        valid_config = 1'b0;
   logic [1:0]  active_channel;
   logic [3:0]  signal_present;
   logic [7:0]  error_count_ch0, error_count_ch1, error_count_ch2, error_count_ch3;
   logic        switch_event;

   always #5 clk = ~clk;

   qos_channel_selector #(
      .SIGNAL_TIMEOUT(ST),
      .ERR_THRESH(8'(ET)),
      .HOLDOFF(HO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pkt_valid(pkt_valid),
      .pkt_err(pkt_err),
      .fallback_enable(fallback_enable),
      .manual_enable(manual_enable),
      .manual_channel(manual_channel),
      .channel_priority(channel_priority),
      .reset_timer(reset_timer),
      .valid_config(valid_config),
      .active_channel(active_channel),
      .signal_present(signal_present),
      .error_count_ch0(error_count_ch0),
      .error_count_ch1(error_count_ch1),
      .error_count_ch2(error_count_ch2),
      .error_count_ch3(error_count_ch3),
      .switch_event(switch_event)
   );

   typedef struct packed {
      logic [1:0] act;
      logic [3:0] pres;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e2;
      logic [7:0] e3;
      logic       sw;
   } obs_t;

   obs_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int mon_cyc = 0;

   // Reference model state, indexed by clock-edge number.
   int cyc = 0;
   int last_pkt[4];
   int errc[4];
   int win_start;
   bit s_fb, s_man;
   int s_mch, s_rt;
   int s_prio[4];
   int act;
   bit pres[4];
   bit sw;
   bit pend;
   int pcand, plen;

   function automatic obs_t model_obs();
      obs_t o;
      o.act  = 2'(act);
      o.pres = {pres[3], pres[2], pres[1], pres[0]};
      o.e0   = 8'(errc[0]);
      o.e1   = 8'(errc[1]);
      o.e2   = 8'(errc[2]);
      o.e3   = 8'(errc[3]);
      o.sw   = sw;
      return o;
   endfunction

   task automatic model_edge(input bit r, input logic [3:0] pv, input logic [3:0] pe, input bit vc);
      bit healthy[4];
      int cand, nxt;
      bit cv, wrap;
      cyc++;
      if (r) begin
         for (int n = 0; n < 4; n++) begin
            last_pkt[n] = -1000000;
            errc[n] = 0;
            pres[n] = 1'b0;
            s_prio[n] = 0;
         end
         win_start = cyc;
         s_fb = 0; s_man = 0; s_mch = 0; s_rt = 0;
         act = 0; sw = 0; pend = 0; pcand = 0; plen = 0;
         return;
      end
      for (int n = 0; n < 4; n++) healthy[n] = pres[n] && (errc[n] < ET);
      cv = 0; cand = 0;
      for (int i = 0; i < 4; i++)
         if (!cv && healthy[s_prio[i]]) begin cand = s_prio[i]; cv = 1; end
      nxt = act;
      if (s_man) begin
         nxt = s_mch; pend = 0;
      end else if (!s_fb) begin
         nxt = s_prio[0]; pend = 0;
      end else if (pend) begin
         if (!cv || cand != pcand || cand == act) pend = 0;
         else if (!healthy[act] || plen == HO) begin nxt = cand; pend = 0; end
         else plen++;
      end else if (cv && cand != act) begin
         if (!healthy[act]) nxt = cand;
         else begin pend = 1; pcand = cand; plen = 1; end
      end
      if (vc) pend = 0;
      wrap = !vc && (s_rt != 0) && (cyc > win_start) && (((cyc - win_start) % s_rt) == 0);
      if (vc || wrap)
         for (int n = 0; n < 4; n++) errc[n] = 0;
      if (vc) win_start = cyc;
      for (int n = 0; n < 4; n++) begin
         if (pv[n] && pe[n] && errc[n] < 255) errc[n]++;
         if (pv[n]) last_pkt[n] = cyc;
         pres[n] = (cyc - last_pkt[n]) < ST;
      end
      sw = (nxt != act);
      act = nxt;
      if (vc) begin
         s_fb = fallback_enable;
         s_man = manual_enable;
         s_mch = int'(manual_channel);
         for (int i = 0; i < 4; i++) s_prio[i] = int'(channel_priority[2*i +: 2]);
         s_rt = int'(reset_timer);
      end
   endtask

   task automatic step(input bit r, input logic [3:0] pv, input logic [3:0] pe, input bit vc);
      @(negedge clk);
      rst = r;
      pkt_valid = pv;
      pkt_err = pe;
      valid_config = vc;
      model_edge(r, pv, pe, vc);
      exp_q.push_back(model_obs());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 4'h0, 4'h0, 0);
   endtask

   task automatic traffic(input int n, input logic [3:0] chans, input logic [3:0] errch);
      for (int i = 0; i < n; i++)
         if (i % 4 == 0) step(0, chans, errch & chans, 0);
         else step(0, 4'h0, 4'h0, 0);
   endtask

   task automatic configure(input bit fb, input bit man, input logic [1:0] mch,
                            input logic [7:0] prio, input logic [19:0] rt);
      fallback_enable = fb;
      manual_enable = man;
      manual_channel = mch;
      channel_priority = prio;
      reset_timer = rt;
      step(0, 4'h0, 4'h0, 1);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = {active_channel, signal_present, error_count_ch0, error_count_ch1,
                 error_count_ch2, error_count_ch3, switch_event};
            mon_cyc++;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle%0d outputs: got act=%0d pres=%b err=%0d/%0d/%0d/%0d sw=%b want act=%0d pres=%b err=%0d/%0d/%0d/%0d sw=%b",
                        mon_cyc, a.act, a.pres, a.e0, a.e1, a.e2, a.e3, a.sw,
                        e.act, e.pres, e.e0, e.e1, e.e2, e.e3, e.sw);
            end
         end
      end
   end

   initial begin
      int rate[4];
      int errp[4];
      for (int n = 0; n < 4; n++) begin rate[n] = 4; errp[n] = 1; end

      // Reset and presence rise/fall on a single packet.
      repeat (3) step(1, 4'h0, 4'h0, 0);
      idle(2);
      step(0, 4'b0001, 4'h0, 0);
      idle(ST + 5);

      // Error saturation on ch2 and clearing at the window wrap.
      configure(0, 0, 2'd0, 8'hE4, 20'd400);
      for (int i = 0; i < 300; i++) step(0, 4'b0100, 4'b0100, 0);
      idle(95);
      for (int i = 0; i < 10; i++) step(0, 4'b0100, 4'b0100, 0);

      // Fallback: ch0 goes bad, then recovers through holdoff, then aborted holdoff.
      traffic(8, 4'hF, 4'h0);
      configure(1, 0, 2'd0, 8'hE4, 20'd200);
      traffic(70, 4'hF, 4'b0001);
      traffic(220, 4'hF, 4'h0);
      traffic(70, 4'hF, 4'b0001);
      configure(1, 0, 2'd0, 8'hE4, 20'd200);
      traffic(4, 4'hF, 4'h0);
      for (int i = 0; i < 16; i++)
         step(0, (i % 4 == 0) ? 4'hF : 4'b0001, 4'b0001, 0);
      traffic(40, 4'hF, 4'h0);

      // Manual override onto an absent channel, then fallback resumes.
      configure(1, 1, 2'd3, 8'hE4, 20'd200);
      traffic(50, 4'b0111, 4'h0);
      configure(1, 0, 2'd0, 8'hE4, 20'd200);
      traffic(40, 4'b0111, 4'h0);

      // Everything absent in fallback, then reset while a holdoff is pending.
      idle(ST + 20);
      traffic(8, 4'hF, 4'h0);
      configure(1, 1, 2'd1, 8'hE4, 20'd0);
      traffic(4, 4'hF, 4'h0);
      configure(1, 0, 2'd0, 8'hE4, 20'd0);
      traffic(10, 4'hF, 4'h0);
      repeat (2) step(1, 4'h0, 4'h0, 0);
      idle(3);

      // Randomized traffic and reconfiguration.
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] pv, pe;
         bit r, vc;
         r = ($urandom_range(0, 599) == 0);
         vc = ($urandom_range(0, 69) == 0);
         if (vc) begin
            fallback_enable = ($urandom_range(0, 4) != 0);
            manual_enable = ($urandom_range(0, 5) == 0);
            manual_channel = 2'($urandom);
            channel_priority = 8'($urandom);
            case ($urandom_range(0, 4))
               0: reset_timer = 20'd0;
               1: reset_timer = 20'd1;
               2: reset_timer = 20'd5;
               3: reset_timer = 20'd60;
               default: reset_timer = 20'd150;
            endcase
            for (int n = 0; n < 4; n++) begin
               rate[n] = $urandom_range(1, 70);
               errp[n] = $urandom_range(0, 4);
            end
         end
         for (int n = 0; n < 4; n++) begin
            pv[n] = ($urandom_range(1, rate[n]) == 1);
            pe[n] = ($urandom_range(0, 3) < errp[n]);
         end
         step(r, pv, pe, vc);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
